// File: rtl/dht11_responder.sv
// dht11_responder
//   Sensor-side DHT11 emulator on a single-wire open-drain bus. It waits for
//   the host start pulse, answers with the 80us low / 80us high acknowledge,
//   then sends a 40-bit frame {hum_int, hum_float, temp_int, temp_float, chk},
//   MSB first. Each bit is a 50us low followed by a 26us (0) or 70us (1) high.
//   The frame ends with a 50us tail low.
//
// Ports
//   clock           system clock
//   reset           asynchronous, active-high reset
//   line_in         raw bus level from the pad (synchronized internally)
//   line_drive_low  1 = pull the bus low, 0 = release it
//   hum_int         humidity integer byte
//   hum_float       humidity fractional byte
//   temp_int        temperature integer byte
//   temp_float      temperature fractional byte
//   corrupt_checksum  (FAULT_INJECT_EN only) flip checksum bit 0 when latched
//   busy            high from start-pulse acceptance until the end of the frame
//   frame_done      one-cycle pulse after the tail low
//
// Optional build macro: FAULT_INJECT_EN adds corrupt_checksum.
module dht11_responder #(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int START_MIN_US  = 18000,
  parameter int RESP_DELAY_US = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       line_in,
  output logic       line_drive_low,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_float,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_float,
`ifdef FAULT_INJECT_EN
  input  logic       corrupt_checksum,
`endif
  output logic       busy,
  output logic       frame_done
);

  localparam int CYC_US = CLK_FREQ_HZ / 1_000_000;
  localparam int CYC_W  = $clog2(CYC_US + 1);
  localparam int US_MAX_A = (START_MIN_US > 80) ? START_MIN_US : 80;
  localparam int US_MAX   = (US_MAX_A > RESP_DELAY_US) ? US_MAX_A : RESP_DELAY_US;
  localparam int US_W     = $clog2(US_MAX + 1);

  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(CYC_US - 1);
  localparam logic [US_W-1:0]  US_SAT    = US_W'(US_MAX);
  localparam logic [US_W-1:0]  START_MIN = US_W'(START_MIN_US);
  localparam logic [US_W-1:0]  T_RESP    = US_W'(RESP_DELAY_US - 1);
  localparam logic [US_W-1:0]  T_ACK     = US_W'(80 - 1);
  localparam logic [US_W-1:0]  T_LOW     = US_W'(50 - 1);
  localparam logic [US_W-1:0]  T_ZERO    = US_W'(26 - 1);
  localparam logic [US_W-1:0]  T_ONE     = US_W'(70 - 1);

  typedef enum logic [2:0] {
    IDLE, START_LOW, WAIT_RESP, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, TAIL_LOW
  } state_t;

  state_t            state, state_next;
  logic              line_p0, line_p1;
  logic [CYC_W-1:0]  cyc_cnt;
  logic [US_W-1:0]   us_cnt;
  logic [5:0]        bit_idx;
  logic [39:0]       frame;
  logic              cyc_last;
  logic              load_frame, idx_load, idx_dec, done_set;
  logic              cur_bit;
  logic [7:0]        chk;

  // The us counter stops at its top value so an endless host low cannot wrap it.
  function automatic logic [US_W-1:0] sat_inc(input logic [US_W-1:0] v);
    return (v == US_SAT) ? v : v + 1'b1;
  endfunction

  // Byte-wise sum, carry discarded by the 8-bit result width.
  function automatic logic [7:0] checksum(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d);
    return a + b + c + d;
  endfunction

  // Stage p0/p1: two-flop synchronizer; the idle bus level is high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      line_p0 <= 1'b1;
      line_p1 <= 1'b1;
    end else begin
      line_p0 <= line_in;
      line_p1 <= line_p0;
    end
  end

  assign cyc_last = (cyc_cnt == CYC_LAST);
  assign cur_bit  = frame[bit_idx];

  always_comb begin
    chk = checksum(hum_int, hum_float, temp_int, temp_float);
`ifdef FAULT_INJECT_EN
    chk = chk ^ {7'b0, corrupt_checksum};
`endif
  end

  always_comb begin
    state_next     = state;
    load_frame     = 1'b0;
    idx_load       = 1'b0;
    idx_dec        = 1'b0;
    done_set       = 1'b0;
    line_drive_low = 1'b0;
    busy           = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (!line_p1) state_next = START_LOW;
      end
      START_LOW: begin
        busy = 1'b0;
        if (line_p1) state_next = (us_cnt >= START_MIN) ? WAIT_RESP : IDLE;
      end
      WAIT_RESP: begin
        if (cyc_last && us_cnt == T_RESP) begin
          load_frame = 1'b1;
          state_next = ACK_LOW;
        end
      end
      ACK_LOW: begin
        line_drive_low = 1'b1;
        if (cyc_last && us_cnt == T_ACK) state_next = ACK_HIGH;
      end
      ACK_HIGH: begin
        if (cyc_last && us_cnt == T_ACK) begin
          idx_load   = 1'b1;
          state_next = BIT_LOW;
        end
      end
      BIT_LOW: begin
        line_drive_low = 1'b1;
        if (cyc_last && us_cnt == T_LOW) state_next = BIT_HIGH;
      end
      BIT_HIGH: begin
        if (cyc_last && us_cnt == (cur_bit ? T_ONE : T_ZERO)) begin
          if (bit_idx == 6'd0) begin
            state_next = TAIL_LOW;
          end else begin
            idx_dec    = 1'b1;
            state_next = BIT_LOW;
          end
        end
      end
      TAIL_LOW: begin
        line_drive_low = 1'b1;
        if (cyc_last && us_cnt == T_LOW) begin
          done_set   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cyc_cnt    <= '0;
      us_cnt     <= '0;
      bit_idx    <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      frame_done <= done_set;
      // Phase timers restart on every state change.
      if (state_next != state) begin
        cyc_cnt <= '0;
        us_cnt  <= '0;
      end else if (cyc_last) begin
        cyc_cnt <= '0;
        us_cnt  <= sat_inc(us_cnt);
      end else begin
        cyc_cnt <= cyc_cnt + 1'b1;
      end
      if (idx_load)     bit_idx <= 6'd39;
      else if (idx_dec) bit_idx <= bit_idx - 1'b1;
    end
  end

  // Frame payload is data only: captured once per frame, no reset needed.
  always_ff @(posedge clock) begin
    if (load_frame) frame <= {hum_int, hum_float, temp_int, temp_float, chk};
  end

endmodule

// File: tb/tb_dht11_responder.sv
module tb_dht11_responder;

  logic       clock = 1'b0;
  logic       reset;
  logic       host_low;
  logic       line_in;
  logic       line_drive_low;
  logic [7:0] hum_int, hum_float, temp_int, temp_float;
  logic [7:0] nxt_hi, nxt_hf, nxt_ti, nxt_tf;
  logic       busy, frame_done;
`ifdef FAULT_INJECT_EN
  logic       corrupt_checksum;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int fd_cnt = 0;

  always #5 clock = ~clock;

  // Open-drain bus: low if either side pulls it low.
  assign line_in = ~(host_low | line_drive_low);

  dht11_responder #(
    .CLK_FREQ_HZ  (1_000_000),
    .START_MIN_US (1000),
    .RESP_DELAY_US(30)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .line_in       (line_in),
    .line_drive_low(line_drive_low),
    .hum_int       (hum_int),
    .hum_float     (hum_float),
    .temp_int      (temp_int),
    .temp_float    (temp_float),
`ifdef FAULT_INJECT_EN
    .corrupt_checksum(corrupt_checksum),
`endif
    .busy          (busy),
    .frame_done    (frame_done)
  );

  always @(negedge clock) if (frame_done === 1'b1) fd_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic host_start(input int us);
    host_low = 1'b1;
    repeat (us) @(negedge clock);
    host_low = 1'b0;
  endtask

  // Called at the first negedge where the drive equals lvl; returns at the
  // first negedge where it differs (or when the bound runs out).
  task automatic run_len(input logic lvl, input int bound, output int n);
    n = 0;
    while (line_drive_low === lvl && n < bound) begin
      n++;
      @(negedge clock);
    end
  endtask

  task automatic rx_frame(input int chg_bit, output logic [39:0] fr, output int pre,
                          output logic busy_ack, output int ack_lo, output int ack_hi,
                          output int bad_lo, output int bad_hi, output int tail);
    int n;
    pre = 0; bad_lo = 0; bad_hi = 0; fr = '0;
    while (line_drive_low !== 1'b1 && pre < 200) begin
      @(negedge clock);
      pre++;
    end
    busy_ack = busy;
    run_len(1'b1, 200, ack_lo);
    run_len(1'b0, 200, ack_hi);
    for (int i = 39; i >= 0; i--) begin
      run_len(1'b1, 200, n);
      if (n != 50) bad_lo++;
      if (i == chg_bit) begin
        hum_int = nxt_hi; hum_float = nxt_hf; temp_int = nxt_ti; temp_float = nxt_tf;
      end
      run_len(1'b0, 200, n);
      if (n != 26 && n != 70) bad_hi++;
      fr[i] = (n > 48);
    end
    run_len(1'b1, 200, tail);
  endtask

  task automatic do_frame(input string name, input logic [39:0] exp, input int chg_bit);
    logic [39:0] fr;
    int pre, ack_lo, ack_hi, bad_lo, bad_hi, tail, fd0;
    logic busy_ack;
    fd0 = fd_cnt;
    host_start(1200);
    rx_frame(chg_bit, fr, pre, busy_ack, ack_lo, ack_hi, bad_lo, bad_hi, tail);
    repeat (5) @(negedge clock);
    check({name, ".resp_delay"}, 64'(pre >= 30 && pre <= 34), 64'd1);
    check({name, ".busy_ack"}, 64'(busy_ack), 64'd1);
    check({name, ".ack_low"}, 64'(ack_lo), 64'd80);
    check({name, ".ack_high"}, 64'(ack_hi), 64'd80);
    check({name, ".bit_low_bad"}, 64'(bad_lo), 64'd0);
    check({name, ".bit_high_bad"}, 64'(bad_hi), 64'd0);
    check({name, ".tail"}, 64'(tail), 64'd50);
    check({name, ".frame"}, 64'(fr), 64'(exp));
    check({name, ".done_pulses"}, 64'(fd_cnt - fd0), 64'd1);
    check({name, ".busy_end"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int ack_n, fd0;
    logic saw_busy, saw_drive;
    reset = 1'b1; host_low = 1'b0;
    hum_int = 8'h00; hum_float = 8'h00; temp_int = 8'h00; temp_float = 8'h00;
    nxt_hi = 8'h00; nxt_hf = 8'h00; nxt_ti = 8'h00; nxt_tf = 8'h00;
`ifdef FAULT_INJECT_EN
    corrupt_checksum = 1'b0;
`endif
    repeat (3) @(negedge clock);
    check("rst.drive", 64'(line_drive_low), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(frame_done), 64'd0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    // Short host low is ignored.
    saw_busy = 1'b0; saw_drive = 1'b0;
    host_low = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      saw_busy |= busy; saw_drive |= line_drive_low;
    end
    host_low = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      saw_busy |= busy; saw_drive |= line_drive_low;
    end
    check("glitch.busy", 64'(saw_busy), 64'd0);
    check("glitch.drive", 64'(saw_drive), 64'd0);
    check("glitch.done", 64'(fd_cnt), 64'd0);

    hum_int = 8'h37; hum_float = 8'h00; temp_int = 8'h18; temp_float = 8'h00;
    do_frame("f37", 40'h37_00_18_00_4F, -1);

    hum_int = 8'hFF; hum_float = 8'hFF; temp_int = 8'h01; temp_float = 8'h02;
    do_frame("fwrap", 40'hFF_FF_01_02_01, -1);

    hum_int = 8'h2A; hum_float = 8'h05; temp_int = 8'h11; temp_float = 8'h03;
    nxt_hi = 8'h12; nxt_hf = 8'h34; nxt_ti = 8'h56; nxt_tf = 8'h78;
    do_frame("fhold", 40'h2A_05_11_03_43, 20);
    do_frame("fnew", 40'h12_34_56_78_14, -1);

`ifdef FAULT_INJECT_EN
    hum_int = 8'h37; hum_float = 8'h00; temp_int = 8'h18; temp_float = 8'h00;
    corrupt_checksum = 1'b1;
    do_frame("fcorrupt", 40'h37_00_18_00_4E, -1);
    corrupt_checksum = 1'b0;
`endif

    // Reset in the middle of the first bit low.
    fd0 = fd_cnt;
    host_start(1200);
    ack_n = 0;
    while (line_drive_low !== 1'b1 && ack_n < 200) begin
      @(negedge clock);
      ack_n++;
    end
    run_len(1'b1, 200, ack_n);
    run_len(1'b0, 200, ack_n);
    repeat (10) @(negedge clock);
    check("midrst.pre_drive", 64'(line_drive_low), 64'd1);
    reset = 1'b1;
    #1;
    check("midrst.drive", 64'(line_drive_low), 64'd0);
    check("midrst.busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    saw_drive = 1'b0; saw_busy = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      saw_busy |= busy; saw_drive |= line_drive_low;
    end
    check("midrst.after_drive", 64'(saw_drive), 64'd0);
    check("midrst.after_busy", 64'(saw_busy), 64'd0);
    check("midrst.done", 64'(fd_cnt - fd0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
